// File: rtl/jt89_noise_gen_if.sv
// Bus bundle for the jt89 noise channel: register strobes and controls in,
// LFSR bit, shift strobe and attenuated sample out.
interface jt89_noise_gen_if;
  logic       clk_en;
  logic       clr;
  logic [2:0] ctrl3;
  logic [3:0] vol;
  logic       tone2;
  logic       noise_bit;
  logic       update;
  logic [8:0] snd;

  modport master (
    output clk_en, clr, ctrl3, vol, tone2,
    input  noise_bit, update, snd
  );

  modport slave (
    input  clk_en, clr, ctrl3, vol, tone2,
    output noise_bit, update, snd
  );
endinterface

// File: rtl/jt89_noise_gen.sv
// jt89 noise channel: parametrised LFSR clocked by a rate divider or by
// tone channel 2 rising edges, followed by the jt89 attenuation stage.
module jt89_vol (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       din,
  input  logic [3:0] vol,
  output logic [8:0] snd
);
  logic [7:0] max;

  // ~2 dB per attenuation step; 15 is mute
  always_comb begin
    max = '0;
    case (vol)
      4'd0:    max = 8'd255;
      4'd1:    max = 8'd203;
      4'd2:    max = 8'd161;
      4'd3:    max = 8'd128;
      4'd4:    max = 8'd102;
      4'd5:    max = 8'd81;
      4'd6:    max = 8'd64;
      4'd7:    max = 8'd51;
      4'd8:    max = 8'd40;
      4'd9:    max = 8'd32;
      4'd10:   max = 8'd26;
      4'd11:   max = 8'd20;
      4'd12:   max = 8'd16;
      4'd13:   max = 8'd13;
      4'd14:   max = 8'd10;
      default: max = 8'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      snd <= '0;
    else if (cen)
      snd <= din ? {1'b0, max} : -{1'b0, max};
  end
endmodule

module jt89_noise_gen #(
  parameter int unsigned       LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] WHITE_TAPS = LFSR_W'(16'h0009),
  parameter logic [LFSR_W-1:0] SEED       = {1'b1, {(LFSR_W-1){1'b0}}},
  parameter int unsigned       DIV_BASE   = 32,
  parameter int unsigned       CNT_W      = 11,
  parameter bit                CLR_CNT    = 1'b0,
  parameter bit                INVERT     = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  jt89_noise_gen_if.slave    bus
);
  localparam logic [LFSR_W-1:0] TOP_BIT = {1'b1, {(LFSR_W-1){1'b0}}};

  logic [LFSR_W-1:0] shift;
  logic [LFSR_W-1:0] shift_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  reload;
  logic [1:0]        rate;
  logic              tone_en;
  logic              tone2_l;
  logic              up_div;
  logic              up_tone;
  logic              up;
  logic              fb;
  logic              noise_bit;
  logic              update;

  // Rate 3 keeps the divider running at the slowest reload; its strobe is ignored
  assign rate    = (bus.ctrl3[1:0] == 2'd3) ? 2'd2 : bus.ctrl3[1:0];
  assign reload  = CNT_W'(DIV_BASE << rate);
  assign up_div  = (cnt == CNT_W'(1));
  assign up_tone = bus.tone2 & ~tone2_l;
  assign up      = tone_en ? up_tone : up_div;

  always_comb begin
    fb        = bus.ctrl3[2] ? ^(shift & WHITE_TAPS) : shift[0];
    shift_nxt = {fb, shift[LFSR_W-1:1]};
    if (shift == '0)
      shift_nxt = TOP_BIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift     <= SEED;
      noise_bit <= SEED[0] ^ INVERT;
      update    <= 1'b0;
      cnt       <= '0;
      tone_en   <= 1'b0;
      tone2_l   <= 1'b0;
    end else begin
      update <= bus.clk_en & up & ~bus.clr;
      // clr is a register write and does not wait for clk_en
      if (bus.clr) begin
        shift     <= SEED;
        noise_bit <= SEED[0] ^ INVERT;
      end else if (bus.clk_en && up) begin
        shift     <= shift_nxt;
        noise_bit <= shift_nxt[0] ^ INVERT;
      end
      if (bus.clr && CLR_CNT)
        cnt <= '0;
      else if (bus.clk_en)
        cnt <= (cnt <= CNT_W'(1)) ? reload : cnt - CNT_W'(1);
      if (bus.clk_en) begin
        tone_en <= (bus.ctrl3[1:0] == 2'd3);
        tone2_l <= bus.tone2;
      end
    end
  end

  assign bus.noise_bit = noise_bit;
  assign bus.update    = update;

  jt89_vol u_vol (
    .clk (clk),
    .rst (rst),
    .cen (bus.clk_en),
    .din (noise_bit),
    .vol (bus.vol),
    .snd (bus.snd)
  );
endmodule

// File: tb/tb_jt89_noise_gen.sv
// Directed bench for jt89_noise_gen: default SN76489 instance plus a
// 15-bit, zero-seed, inverted, counter-restarting instance.
module tb_jt89_noise_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  jt89_noise_gen_if bus ();
  jt89_noise_gen_if bus2 ();

  assign bus2.clk_en = bus.clk_en;
  assign bus2.clr    = bus.clr;
  assign bus2.ctrl3  = bus.ctrl3;
  assign bus2.vol    = bus.vol;
  assign bus2.tone2  = bus.tone2;

  jt89_noise_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  jt89_noise_gen #(
    .LFSR_W     (15),
    .WHITE_TAPS (15'h0003),
    .SEED       (15'h0000),
    .DIV_BASE   (4),
    .CNT_W      (5),
    .CLR_CNT    (1'b1),
    .INVERT     (1'b1)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    int         ticks;
    logic [2:0] ctrl3;
    logic [3:0] vol;
    logic       tone2;
    int         exp_upd;
    logic       exp_nb;
    logic       chk_snd;
    logic [8:0] exp_snd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(output logic upd);
    @(negedge clk);
    bus.clk_en = 1'b1;
    @(negedge clk);
    bus.clk_en = 1'b0;
    upd = bus.update;
  endtask

  task automatic run_ticks(input int n, output int nupd);
    logic u;
    nupd = 0;
    for (int i = 0; i < n; i++) begin
      tick(u);
      if (u) nupd++;
    end
  endtask

  task automatic wait_upd2(output int n);
    logic u;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(u);
      n++;
      if (bus2.update) break;
    end
  endtask

  task automatic pulse_rst;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_nb", {31'b0, bus.noise_bit}, 32'd0);
    check("rst_upd", {31'b0, bus.update}, 32'd0);
    check("rst_snd", {23'b0, bus.snd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [15:0] m;
  logic [14:0] m2;
  logic        u;
  int          n;

  initial begin
    bus.clk_en = 1'b0;
    bus.clr    = 1'b0;
    bus.ctrl3  = 3'b000;
    bus.vol    = 4'd0;
    bus.tone2  = 1'b0;

    // divider, rate changes, attenuation and tone-sync vectors, applied back to back
    vecs.push_back('{33,  3'b000, 4'd0,  1'b0, 1,  1'b0, 1'b1, 9'h101});
    vecs.push_back('{416, 3'b000, 4'd0,  1'b0, 13, 1'b0, 1'b1, 9'h101});
    vecs.push_back('{32,  3'b000, 4'd0,  1'b0, 1,  1'b1, 1'b1, 9'h101});
    vecs.push_back('{1,   3'b000, 4'd0,  1'b0, 0,  1'b1, 1'b1, 9'h0ff});
    vecs.push_back('{31,  3'b000, 4'd0,  1'b0, 1,  1'b0, 1'b1, 9'h0ff});
    vecs.push_back('{1,   3'b000, 4'd15, 1'b0, 0,  1'b0, 1'b1, 9'h000});
    vecs.push_back('{1,   3'b000, 4'd3,  1'b0, 0,  1'b0, 1'b1, 9'h180});
    vecs.push_back('{30,  3'b001, 4'd0,  1'b0, 1,  1'b0, 1'b1, 9'h101});
    vecs.push_back('{64,  3'b001, 4'd0,  1'b0, 1,  1'b0, 1'b0, 9'h000});
    vecs.push_back('{64,  3'b010, 4'd0,  1'b0, 1,  1'b0, 1'b0, 9'h000});
    vecs.push_back('{128, 3'b010, 4'd0,  1'b0, 1,  1'b0, 1'b0, 9'h000});
    vecs.push_back('{300, 3'b011, 4'd0,  1'b0, 0,  1'b0, 1'b0, 9'h000});
    for (int j = 0; j < 22; j++)
      vecs.push_back('{10, 3'b011, 4'd0, (j % 2 == 0), (j % 2 == 0) ? 1 : 0,
                       (j >= 20), 1'b0, 9'h000});

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_nb", {31'b0, bus.noise_bit}, 32'd0);
    check("reset_upd", {31'b0, bus.update}, 32'd0);
    check("reset_snd", {23'b0, bus.snd}, 32'd0);
    check("reset_nb2", {31'b0, bus2.noise_bit}, 32'd1);

    foreach (vecs[i]) begin
      bus.ctrl3 = vecs[i].ctrl3;
      bus.vol   = vecs[i].vol;
      bus.tone2 = vecs[i].tone2;
      run_ticks(vecs[i].ticks, n);
      check($sformatf("vec%0d_upd", i), n, vecs[i].exp_upd);
      check($sformatf("vec%0d_nb", i), {31'b0, bus.noise_bit}, {31'b0, vecs[i].exp_nb});
      if (vecs[i].chk_snd)
        check($sformatf("vec%0d_snd", i), {23'b0, bus.snd}, {23'b0, vecs[i].exp_snd});
    end

    // white mode from seed against a reference LFSR, one shift per tone2 edge
    bus.ctrl3 = 3'b111;
    bus.tone2 = 1'b0;
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("clr_nb", {31'b0, bus.noise_bit}, 32'd0);
    m = 16'h8000;
    for (int k = 0; k < 200; k++) begin
      bus.tone2 = 1'b1;
      tick(u);
      check("white_upd", {31'b0, u}, 32'd1);
      m = (m == '0) ? 16'h8000 : {^(m & 16'h0009), m[15:1]};
      check($sformatf("white_nb%0d", k), {31'b0, bus.noise_bit}, {31'b0, m[0]});
      bus.tone2 = 1'b0;
      tick(u);
      check("white_idle", {31'b0, u}, 32'd0);
    end

    // clr landing on the same clk_en as a tone2 rising edge
    @(negedge clk);
    bus.clk_en = 1'b1;
    bus.clr    = 1'b1;
    bus.tone2  = 1'b1;
    @(negedge clk);
    bus.clk_en = 1'b0;
    bus.clr    = 1'b0;
    check("clr_coinc_upd", {31'b0, bus.update}, 32'd0);
    check("clr_coinc_nb", {31'b0, bus.noise_bit}, 32'd0);
    bus.ctrl3 = 3'b011;
    for (int k = 1; k <= 15; k++) begin
      bus.tone2 = 1'b0;
      tick(u);
      bus.tone2 = 1'b1;
      tick(u);
      if (k == 14) check("periodic_nb14", {31'b0, bus.noise_bit}, 32'd0);
      if (k == 15) check("periodic_nb15", {31'b0, bus.noise_bit}, 32'd1);
    end

    // reset mid-count: first reload after reset must not shift
    bus.ctrl3 = 3'b000;
    bus.tone2 = 1'b0;
    run_ticks(10, n);
    pulse_rst();
    run_ticks(32, n);
    check("post_rst_noupd", n, 0);
    run_ticks(1, n);
    check("post_rst_upd", n, 1);

    // 15-bit zero-seed instance: lock-up recovery, taps 0/1, inverted output
    bus.ctrl3 = 3'b100;
    pulse_rst();
    check("d2_reset_nb", {31'b0, bus2.noise_bit}, 32'd1);
    wait_upd2(n);
    check("d2_first_upd", n, 5);
    check("d2_lockup_nb", {31'b0, bus2.noise_bit}, 32'd1);
    m2 = 15'h4000;
    for (int k = 0; k < 60; k++) begin
      wait_upd2(n);
      check("d2_period", n, 4);
      m2 = (m2 == '0) ? 15'h4000 : {m2[0] ^ m2[1], m2[14:1]};
      check($sformatf("d2_nb%0d", k), {31'b0, bus2.noise_bit}, {31'b0, ~m2[0]});
    end
    run_ticks(2, n);
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("d2_clr_nb", {31'b0, bus2.noise_bit}, 32'd1);
    wait_upd2(n);
    check("d2_clr_cnt", n, 5);
    check("d2_clr_lockup_nb", {31'b0, bus2.noise_bit}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
